// File: rtl/mul_operand_sequencer_if.sv
// Byte-stream interface for the operand sequencer: operand input stream and product output stream.
// Valid/ready: a beat moves on a rising clk edge where valid and ready are both high; a valid source holds its beat until then.
interface mul_operand_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mul_operand_sequencer.sv
// Sequences a shared combinational multiplier: takes operands A then B, waits LAT settle cycles,
// captures the product and returns it low byte first.
module mul_operand_sequencer #(
  parameter int WIDTH = 8,
  parameter int LAT   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mul_operand_sequencer_if.slave io,
  output logic [WIDTH-1:0]       mul_a,
  output logic [WIDTH-1:0]       mul_b,
  input  logic [2*WIDTH-1:0]     mul_p,
  output logic                   busy,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_GET_A  = 3'd0,
    S_GET_B  = 3'd1,
    S_WAIT   = 3'd2,
    S_OUT_LO = 3'd3,
    S_OUT_HI = 3'd4
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic [2*WIDTH-1:0] product;

  assign dbg_state = state;

  // Every handshake output is registered and updated together with the state it belongs to,
  // so in_ready, out_valid, out_data and out_last never depend combinationally on inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_GET_A;
      mul_a        <= '0;
      mul_b        <= '0;
      product      <= '0;
      cnt          <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.out_last  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        S_GET_A: begin
          if (io.in_valid && io.in_ready) begin
            mul_a <= io.in_data;
            busy  <= 1'b1;
            state <= S_GET_B;
          end
        end
        S_GET_B: begin
          if (io.in_valid && io.in_ready) begin
            mul_b       <= io.in_data;
            cnt         <= CNT_INIT;
            io.in_ready <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Counter is loaded with LAT-1 and capture happens on the zero cycle: LAT cycles total.
          if (cnt == 4'd0) begin
            product      <= mul_p;
            io.out_data  <= mul_p[WIDTH-1:0];
            io.out_last  <= 1'b0;
            io.out_valid <= 1'b1;
            state        <= S_OUT_LO;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_OUT_LO: begin
          if (io.out_valid && io.out_ready) begin
            io.out_data <= product[2*WIDTH-1:WIDTH];
            io.out_last <= 1'b1;
            state       <= S_OUT_HI;
          end
        end
        S_OUT_HI: begin
          if (io.out_valid && io.out_ready) begin
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
            io.in_ready  <= 1'b1;
            busy         <= 1'b0;
            state        <= S_GET_A;
          end
        end
        default: begin
          state        <= S_GET_A;
          io.in_ready  <= 1'b1;
          io.out_valid <= 1'b0;
          io.out_last  <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
